mure_retire_serializer: RTL

MURE_RETIRE_SERIALIZER -- requirements
Module: mure_retire_serializer

---
 rtl/mure_retire_if.sv | 56 +++++
 rtl/mure_retire_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mure_retire_if.sv
// Retire-port bundle between the core retire stage, the serializer and the trace encoder.
// The serializer takes the slave view; the retire stage and encoder take the master view.
interface mure_retire_if #(
    parameter int NRET      = 2,
    parameter int XLEN      = 32,
    parameter int INST_LEN  = 32,
    parameter int PRIV_LEN  = 2,
    parameter int CAUSE_LEN = 32
);
    logic [NRET-1:0]          valid_i;
    logic [NRET*XLEN-1:0]     pc_i;
    logic [NRET*INST_LEN-1:0] inst_i;
    logic [NRET-1:0]          compressed_i;
    logic                     exception_i;
    logic                     interrupt_i;
    logic                     eret_i;
    logic [PRIV_LEN-1:0]      priv_lvl_i;
    logic [CAUSE_LEN-1:0]     ucause_i;
    logic [CAUSE_LEN-1:0]     scause_i;
    logic [CAUSE_LEN-1:0]     vscause_i;
    logic [CAUSE_LEN-1:0]     mcause_i;
    logic [XLEN-1:0]          utval_i;
    logic [XLEN-1:0]          stval_i;
    logic [XLEN-1:0]          vstval_i;
    logic [XLEN-1:0]          mtval_i;
    logic                     inst_ready_i;

    logic                     inst_valid_o;
    logic                     iretired_o;
    logic                     exception_o;
    logic                     interrupt_o;
    logic                     eret_o;
    logic                     compressed_o;
    logic [INST_LEN-1:0]      inst_data_o;
    logic [XLEN-1:0]          pc_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [XLEN-1:0]          tval_o;
    logic                     overflow_o;
    logic [15:0]              drop_cnt_o;

    modport slave (
        input  valid_i, pc_i, inst_i, compressed_i, exception_i, interrupt_i, eret_i,
               priv_lvl_i, ucause_i, scause_i, vscause_i, mcause_i,
               utval_i, stval_i, vstval_i, mtval_i, inst_ready_i,
        output inst_valid_o, iretired_o, exception_o, interrupt_o, eret_o, compressed_o,
               inst_data_o, pc_o, cause_o, tval_o, overflow_o, drop_cnt_o
    );

    modport master (
        output valid_i, pc_i, inst_i, compressed_i, exception_i, interrupt_i, eret_i,
               priv_lvl_i, ucause_i, scause_i, vscause_i, mcause_i,
               utval_i, stval_i, vstval_i, mtval_i, inst_ready_i,
        input  inst_valid_o, iretired_o, exception_o, interrupt_o, eret_o, compressed_o,
               inst_data_o, pc_o, cause_o, tval_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/mure_retire_serializer.sv
// Compacts up to NRET retired instructions per cycle into a FIFO drained one entry per cycle.
// Optional MURE_DROP_CNT_EN enables the saturating dropped-entry counter on drop_cnt_o.
module mure_retire_serializer #(
    parameter int NRET      = 2,
    parameter int DEPTH     = 8,
    parameter int XLEN      = 32,
    parameter int INST_LEN  = 32,
    parameter int PRIV_LEN  = 2,
    parameter int CAUSE_LEN = 32
) (
    input logic         clk_i,
    input logic         rst_ni,
    mure_retire_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                 iretired;
        logic                 exception;
        logic                 interrupt;
        logic                 eret;
        logic                 compressed;
        logic [INST_LEN-1:0]  inst;
        logic [XLEN-1:0]      pc;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } entry_t;

    entry_t              mem_r [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [CNT_W-1:0]    count_r;
    entry_t              head_r;
    logic                head_valid_r;
    logic                overflow_r;

    entry_t              new_e_s [NRET];
    int                  k_int;
    int                  last_int;
    logic [CNT_W-1:0]    k_ext_s;
    logic [CAUSE_LEN-1:0] cause_sel_s;
    logic [XLEN-1:0]     tval_sel_s;
    logic                accept_s;
    logic                drop_s;
    logic                pop_s;
    logic [CNT_W-1:0]    free_s;
    logic [CNT_W-1:0]    after_pop_s;
    logic [CNT_W-1:0]    count_next_s;
    logic [PTR_W-1:0]    rd_next_s;
    entry_t              head_next_s;

    // Trap cause/tval picked by the privilege level in force when the lanes are sampled.
    always_comb begin
        cause_sel_s = '0;
        tval_sel_s  = '0;
        case (bus.priv_lvl_i[1:0])
            2'b11:   begin cause_sel_s = bus.mcause_i;  tval_sel_s = bus.mtval_i;  end
            2'b10:   begin cause_sel_s = bus.vscause_i; tval_sel_s = bus.vstval_i; end
            2'b01:   begin cause_sel_s = bus.scause_i;  tval_sel_s = bus.stval_i;  end
            default: begin cause_sel_s = bus.ucause_i;  tval_sel_s = bus.utval_i;  end
        endcase
    end

    // Lane compaction; trap qualifiers ride only on the youngest entry of the cycle.
    always_comb begin
        for (int j = 0; j < NRET; j++) begin
            new_e_s[j] = '0;
        end
        k_int    = 0;
        last_int = 0;
        for (int i = 0; i < NRET; i++) begin
            if (bus.valid_i[i]) begin
                new_e_s[k_int].iretired   = 1'b1;
                new_e_s[k_int].pc         = bus.pc_i[i*XLEN +: XLEN];
                new_e_s[k_int].inst       = bus.inst_i[i*INST_LEN +: INST_LEN];
                new_e_s[k_int].compressed = bus.compressed_i[i];
                last_int                  = k_int;
                k_int                     = k_int + 1;
            end else begin
                last_int = last_int;
            end
        end
        if (k_int != 0) begin
            new_e_s[last_int].exception = bus.exception_i;
            new_e_s[last_int].interrupt = bus.interrupt_i & bus.exception_i;
            new_e_s[last_int].eret      = bus.eret_i;
            new_e_s[last_int].cause     = cause_sel_s;
            new_e_s[last_int].tval      = tval_sel_s;
        end else if (bus.exception_i || bus.eret_i) begin
            // Trap with no retiring instruction still needs a trace record.
            new_e_s[0].iretired  = 1'b0;
            new_e_s[0].pc        = bus.pc_i[XLEN-1:0];
            new_e_s[0].exception = bus.exception_i;
            new_e_s[0].interrupt = bus.interrupt_i & bus.exception_i;
            new_e_s[0].eret      = bus.eret_i;
            new_e_s[0].cause     = cause_sel_s;
            new_e_s[0].tval      = tval_sel_s;
            k_int                = 1;
        end else begin
            k_int = 0;
        end
    end

    // All-or-nothing push against start-of-cycle free space, plus next-head prediction.
    always_comb begin
        k_ext_s      = CNT_W'(k_int);
        free_s       = CNT_W'(DEPTH) - count_r;
        accept_s     = (k_int != 0) && (free_s >= k_ext_s);
        drop_s       = (k_int != 0) && !accept_s;
        pop_s        = head_valid_r & bus.inst_ready_i;
        after_pop_s  = count_r - CNT_W'(pop_s);
        count_next_s = after_pop_s + (accept_s ? k_ext_s : {CNT_W{1'b0}});
        rd_next_s    = rd_ptr_r + PTR_W'(pop_s);
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_next_s = '0;
        end else if (after_pop_s != {CNT_W{1'b0}}) begin
            head_next_s = mem_r[rd_next_s];
        end else begin
            // FIFO drained this cycle: the write pointer equals rd_next_s, so the head is the first new entry.
            head_next_s = new_e_s[0];
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NRET; j++) begin
                if (accept_s && (j < k_int)) begin
                    mem_r[wr_ptr_r + PTR_W'(j)] <= new_e_s[j];
                end
            end
        end
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            head_r       <= '0;
            head_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            rd_ptr_r     <= rd_next_s;
            wr_ptr_r     <= wr_ptr_r + (accept_s ? PTR_W'(k_int) : {PTR_W{1'b0}});
            count_r      <= count_next_s;
            head_r       <= head_next_s;
            head_valid_r <= (count_next_s != {CNT_W{1'b0}});
            overflow_r   <= overflow_r | drop_s;
        end
    end

`ifdef MURE_DROP_CNT_EN
    logic [15:0] drop_cnt_r;
    logic [16:0] drop_sum_s;

    // Saturating sum of dropped entries.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r} + 17'(k_int);
    end

    // Dropped-entry counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s) begin
            drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.drop_cnt_o = drop_cnt_r;
`else
    assign bus.drop_cnt_o = 16'h0000;
`endif

    assign bus.inst_valid_o = head_valid_r;
    assign bus.iretired_o   = head_r.iretired;
    assign bus.exception_o  = head_r.exception;
    assign bus.interrupt_o  = head_r.interrupt;
    assign bus.eret_o       = head_r.eret;
    assign bus.compressed_o = head_r.compressed;
    assign bus.inst_data_o  = head_r.inst;
    assign bus.pc_o         = head_r.pc;
    assign bus.cause_o      = head_r.cause;
    assign bus.tval_o       = head_r.tval;
    assign bus.overflow_o   = overflow_r;
endmodule
